// File: rtl/dk_input_ctrl.sv
// dk_input_ctrl
// Input front end for dkong_top. It turns PS/2 key events and merged joystick
// bits into player 1/2 controls, start buttons and a shaped coin pulse.
// When the cabinet is turned sideways, the directions are rotated by 90 degrees.
// Each coin request becomes a fixed-width pulse followed by a guard gap.
// Up to three further coins can wait in a small queue.
// All outputs are active-high. The top level inverts them for dkong_top.
//
// Parameters
//   COIN_PULSE_CYC  cycles O_COIN is held high per coin (>= 1)
//   COIN_GAP_CYC    minimum low cycles after each pulse (>= 1)
//   CNT_W           coin timer width, holds max(COIN_PULSE_CYC, COIN_GAP_CYC)
// Ports
//   I_CLK_24576M  in   system clock
//   I_RESETn      in   asynchronous active-low reset
//   I_PS2_KEY     in   [10]=event toggle, [9]=pressed, [8:0]=scan code
//   I_JOY         in   [0]R [1]L [2]D [3]U [4]fire [5]start1 [6]start2
//   I_ROTATE      in   1 = horizontal orientation, remap directions
//   I_AUTO_COIN   in   1 = start presses also request a coin
//   O_P1, O_P2    out  {fire,right,left,down,up}
//   O_START1/2    out  start buttons
//   O_COIN        out  shaped coin pulse
//   O_COIN_PEND   out  queued coin count 0..3
module dk_input_ctrl #(
  parameter int COIN_PULSE_CYC = 1228800,
  parameter int COIN_GAP_CYC   = 1228800,
  parameter int CNT_W          = 22
) (
  input  logic        I_CLK_24576M,
  input  logic        I_RESETn,
  input  logic [10:0] I_PS2_KEY,
  input  logic [15:0] I_JOY,
  input  logic        I_ROTATE,
  input  logic        I_AUTO_COIN,
  output logic [4:0]  O_P1,
  output logic [4:0]  O_P2,
  output logic        O_START1,
  output logic        O_START2,
  output logic        O_COIN,
  output logic [1:0]  O_COIN_PEND
);

  localparam logic [CNT_W-1:0] PULSE_LOAD = CNT_W'(COIN_PULSE_CYC - 1);
  localparam logic [CNT_W-1:0] GAP_LOAD   = CNT_W'(COIN_GAP_CYC - 1);
  localparam logic [CNT_W-1:0] TIMER_ONE  = CNT_W'(1);

  typedef enum logic [1:0] {
    COIN_IDLE  = 2'd0,
    COIN_PULSE = 2'd1,
    COIN_GAP   = 2'd2
  } coin_state_t;

  // Only bits [6:0] of the merged joystick word carry controls.
  logic unused_joy_bits;
  assign unused_joy_bits = ^I_JOY[15:7];

  logic tog_q;
  logic armed;
  logic key_event;
  logic [8:0] scan_code;
  logic pressed;

  logic k_up1, k_down1, k_left1, k_right1, k_fire1;
  logic k_up2, k_down2, k_left2, k_right2, k_fire2;
  logic k_f1, k_f2, k_1, k_2, k_coin1, k_coin2;

  assign scan_code = I_PS2_KEY[8:0];
  assign pressed   = I_PS2_KEY[9];
  // Before the first clock after reset, the tracker has not yet seen the
  // toggle line. A stale toggle level must not count as an event.
  assign key_event = armed && (I_PS2_KEY[10] != tog_q);

  always_ff @(posedge I_CLK_24576M or negedge I_RESETn) begin
    if (!I_RESETn) begin
      tog_q    <= 1'b0;
      armed    <= 1'b0;
      k_up1    <= 1'b0;
      k_down1  <= 1'b0;
      k_left1  <= 1'b0;
      k_right1 <= 1'b0;
      k_fire1  <= 1'b0;
      k_up2    <= 1'b0;
      k_down2  <= 1'b0;
      k_left2  <= 1'b0;
      k_right2 <= 1'b0;
      k_fire2  <= 1'b0;
      k_f1     <= 1'b0;
      k_f2     <= 1'b0;
      k_1      <= 1'b0;
      k_2      <= 1'b0;
      k_coin1  <= 1'b0;
      k_coin2  <= 1'b0;
    end else begin
      tog_q <= I_PS2_KEY[10];
      armed <= 1'b1;
      if (key_event) begin
        // Arrow keys match on the low byte only. Extended and keypad
        // variants therefore behave the same.
        case (scan_code[7:0])
          8'h75:   k_up1    <= pressed;
          8'h72:   k_down1  <= pressed;
          8'h6B:   k_left1  <= pressed;
          8'h74:   k_right1 <= pressed;
          default: ;
        endcase
        case (scan_code)
          9'h029, 9'h014: k_fire1 <= pressed;
          9'h005:  k_f1    <= pressed;
          9'h006:  k_f2    <= pressed;
          9'h016:  k_1     <= pressed;
          9'h01E:  k_2     <= pressed;
          9'h02E:  k_coin1 <= pressed;
          9'h036:  k_coin2 <= pressed;
          9'h02D:  k_up2   <= pressed;
          9'h02B:  k_down2 <= pressed;
          9'h023:  k_left2 <= pressed;
          9'h034:  k_right2 <= pressed;
          9'h01C:  k_fire2 <= pressed;
          default: ;
        endcase
      end
    end
  end

  // Returns {right,left,down,up}. When rotated: up<-left, down<-right,
  // left<-down, right<-up.
  function automatic logic [3:0] remap(input logic rot, input logic u,
                                       input logic d, input logic l,
                                       input logic r);
    return rot ? {u, d, r, l} : {r, l, d, u};
  endfunction

  logic [3:0] p1_dir, p2_dir;
  logic fire1_c, fire2_c, start1_c, start2_c;

  assign p1_dir   = remap(I_ROTATE, k_up1 | I_JOY[3], k_down1 | I_JOY[2],
                          k_left1 | I_JOY[1], k_right1 | I_JOY[0]);
  assign p2_dir   = remap(I_ROTATE, k_up2 | I_JOY[3], k_down2 | I_JOY[2],
                          k_left2 | I_JOY[1], k_right2 | I_JOY[0]);
  assign fire1_c  = k_fire1 | I_JOY[4];
  assign fire2_c  = k_fire2 | I_JOY[4];
  assign start1_c = k_f1 | k_1 | I_JOY[5];
  assign start2_c = k_f2 | k_2 | I_JOY[6];

  always_ff @(posedge I_CLK_24576M or negedge I_RESETn) begin
    if (!I_RESETn) begin
      O_P1     <= 5'd0;
      O_P2     <= 5'd0;
      O_START1 <= 1'b0;
      O_START2 <= 1'b0;
    end else begin
      O_P1     <= {fire1_c, p1_dir};
      O_P2     <= {fire2_c, p2_dir};
      O_START1 <= start1_c;
      O_START2 <= start2_c;
    end
  end

  logic coin_lvl, coin_lvl_q, coin_req, dequeue;
  coin_state_t coin_state;
  logic [CNT_W-1:0] coin_timer;
  logic [1:0] pend, pend_next;

  // While a coin key stays held, it produces exactly one request.
  assign coin_lvl = k_coin1 | k_coin2 | (I_AUTO_COIN & (start1_c | start2_c));
  assign coin_req = coin_lvl & ~coin_lvl_q;
  assign dequeue  = (coin_state == COIN_IDLE) && (pend != 2'd0);

  // A request and a dequeue in the same cycle cancel out, even when the
  // queue is full. Otherwise a request into a full queue is dropped.
  always_comb begin
    pend_next = pend;
    case ({coin_req, dequeue})
      2'b10:   pend_next = (pend == 2'd3) ? 2'd3 : pend + 2'd1;
      2'b01:   pend_next = pend - 2'd1;
      default: pend_next = pend;
    endcase
  end

  assign O_COIN_PEND = pend;

  always_ff @(posedge I_CLK_24576M or negedge I_RESETn) begin
    if (!I_RESETn) begin
      coin_state <= COIN_IDLE;
      coin_timer <= '0;
      coin_lvl_q <= 1'b0;
      pend       <= 2'd0;
      O_COIN     <= 1'b0;
    end else begin
      coin_lvl_q <= coin_lvl;
      pend       <= pend_next;
      case (coin_state)
        COIN_IDLE: begin
          if (pend != 2'd0) begin
            coin_state <= COIN_PULSE;
            coin_timer <= PULSE_LOAD;
            O_COIN     <= 1'b1;
          end
        end
        COIN_PULSE: begin
          if (coin_timer == '0) begin
            coin_state <= COIN_GAP;
            coin_timer <= GAP_LOAD;
            O_COIN     <= 1'b0;
          end else begin
            coin_timer <= coin_timer - TIMER_ONE;
          end
        end
        COIN_GAP: begin
          if (coin_timer == '0) begin
            coin_state <= COIN_IDLE;
          end else begin
            coin_timer <= coin_timer - TIMER_ONE;
          end
        end
        default: begin
          coin_state <= COIN_IDLE;
          O_COIN     <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dk_input_ctrl.sv
// tb_dk_input_ctrl
// Scoreboard bench for dk_input_ctrl, built with short coin timing
// (4-cycle pulse, 3-cycle gap). The stimulus pushes the expected control
// words and coin pulse widths into queues. Two monitors pop from these
// queues when the DUT outputs change.
module tb_dk_input_ctrl;

  logic clk = 1'b0;
  logic rst_n;
  logic [10:0] ps2Key;
  logic [15:0] joy;
  logic rotate;
  logic autoCoin;
  logic [4:0] p1, p2;
  logic start1, start2, coin;
  logic [1:0] coinPend;

  int checkCount = 0;
  int passCount = 0;

  logic [11:0] ctrlExpQ[$];
  string ctrlNameQ[$];
  int coinExpQ[$];
  logic [11:0] prevCtrl = 12'd0;
  logic [11:0] curCtrl;
  int pendPeak = 0;
  bit inPulse = 0;
  bit havePrev = 0;
  int highCnt = 0;
  int lowCnt = 0;

  dk_input_ctrl #(
    .COIN_PULSE_CYC(4),
    .COIN_GAP_CYC(3),
    .CNT_W(22)
  ) dut (
    .I_CLK_24576M(clk),
    .I_RESETn(rst_n),
    .I_PS2_KEY(ps2Key),
    .I_JOY(joy),
    .I_ROTATE(rotate),
    .I_AUTO_COIN(autoCoin),
    .O_P1(p1),
    .O_P2(p2),
    .O_START1(start1),
    .O_START2(start2),
    .O_COIN(coin),
    .O_COIN_PEND(coinPend)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checkCount++;
    if (actual === expected) passCount++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
  endtask

  function automatic logic [11:0] mk(input logic [4:0] a, input logic [4:0] b,
                                     input logic s1, input logic s2);
    return {a, b, s1, s2};
  endfunction

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic ps2Event(input logic [8:0] code, input logic isPress);
    ps2Key = {~ps2Key[10], isPress, code};
    tick(1);
  endtask

  // The expected control word is queued before the key event is driven.
  task automatic applyStimulus(input string name, input logic [8:0] code,
                               input logic [11:0] expPress);
    ctrlExpQ.push_back(expPress);
    ctrlNameQ.push_back({name, "_press"});
    ps2Event(code, 1'b1);
    tick(4);
    ctrlExpQ.push_back(12'd0);
    ctrlNameQ.push_back({name, "_release"});
    ps2Event(code, 1'b0);
    tick(4);
  endtask

  always @(negedge clk) begin
    curCtrl = {p1, p2, start1, start2};
    if (rst_n && curCtrl != prevCtrl) begin
      if (ctrlExpQ.size() == 0) checkOutput("ctrl_unexpected", {20'd0, curCtrl}, {20'd0, prevCtrl});
      else checkOutput(ctrlNameQ.pop_front(), {20'd0, curCtrl}, {20'd0, ctrlExpQ.pop_front()});
    end
    prevCtrl = curCtrl;
  end

  always @(negedge clk) begin
    if (!rst_n) begin
      inPulse = 0;
      havePrev = 0;
      highCnt = 0;
      lowCnt = 0;
    end else begin
      if (coin) begin
        if (!inPulse) begin
          inPulse = 1;
          highCnt = 0;
          if (havePrev) checkOutput("coin_gap_at_least_4", {31'd0, lowCnt >= 4}, 32'd1);
        end
        highCnt++;
      end else begin
        if (inPulse) begin
          inPulse = 0;
          havePrev = 1;
          lowCnt = 0;
          if (coinExpQ.size() == 0) checkOutput("coin_unexpected_pulse", 32'd1, 32'd0);
          else checkOutput("coin_width", highCnt, coinExpQ.pop_front());
        end
        lowCnt++;
      end
      if (int'(coinPend) > pendPeak) pendPeak = int'(coinPend);
    end
  end

  initial begin
    int waitCnt;
    rst_n = 1'b0;
    ps2Key = 11'h675;
    joy = 16'd0;
    rotate = 1'b0;
    autoCoin = 1'b0;
    #23;
    checkOutput("reset_ctrl", {20'd0, p1, p2, start1, start2}, 32'd0);
    checkOutput("reset_coin", {31'd0, coin}, 32'd0);
    checkOutput("reset_pend", {30'd0, coinPend}, 32'd0);
    tick(1);
    rst_n = 1'b1;
    tick(5);
    checkOutput("post_reset_no_event", {20'd0, p1, p2, start1, start2}, 32'd0);

    applyStimulus("up1_direct", 9'h075, mk(5'b00001, 5'd0, 0, 0));
    applyStimulus("fire1", 9'h029, mk(5'b10000, 5'd0, 0, 0));
    applyStimulus("right1_ext", 9'h174, mk(5'b01000, 5'd0, 0, 0));
    applyStimulus("up2", 9'h02D, mk(5'd0, 5'b00001, 0, 0));
    applyStimulus("left2", 9'h023, mk(5'd0, 5'b00100, 0, 0));
    applyStimulus("fire2", 9'h01C, mk(5'd0, 5'b10000, 0, 0));
    applyStimulus("f2_start2", 9'h006, mk(5'd0, 5'd0, 0, 1));
    applyStimulus("key1_start1", 9'h016, mk(5'd0, 5'd0, 1, 0));
    ps2Event(9'h01A, 1'b1);
    tick(3);
    ps2Event(9'h01A, 1'b0);
    tick(3);

    ctrlExpQ.push_back(mk(5'b00001, 5'd0, 0, 0)); ctrlNameQ.push_back("consec_up");
    ctrlExpQ.push_back(mk(5'b00011, 5'd0, 0, 0)); ctrlNameQ.push_back("consec_up_down");
    ps2Event(9'h075, 1'b1);
    ps2Event(9'h072, 1'b1);
    tick(3);
    ctrlExpQ.push_back(mk(5'b00010, 5'd0, 0, 0)); ctrlNameQ.push_back("consec_rel_up");
    ctrlExpQ.push_back(12'd0); ctrlNameQ.push_back("consec_rel_down");
    ps2Event(9'h075, 1'b0);
    ps2Event(9'h072, 1'b0);
    tick(3);

    rotate = 1'b1;
    tick(2);
    applyStimulus("rot_left1_to_up", 9'h06B, mk(5'b00001, 5'd0, 0, 0));
    applyStimulus("rot_left2_to_up", 9'h023, mk(5'd0, 5'b00001, 0, 0));
    ctrlExpQ.push_back(mk(5'b01000, 5'b01000, 0, 0)); ctrlNameQ.push_back("rot_joy_up_to_right");
    joy = 16'h0008;
    tick(4);
    ctrlExpQ.push_back(12'd0); ctrlNameQ.push_back("rot_joy_release");
    joy = 16'h0000;
    tick(4);
    rotate = 1'b0;
    tick(2);

    coinExpQ.push_back(4);
    ps2Event(9'h02E, 1'b1);
    tick(100);
    ps2Event(9'h02E, 1'b0);
    tick(20);
    checkOutput("held_coin_pend_zero", {30'd0, coinPend}, 32'd0);

    pendPeak = 0;
    repeat (4) coinExpQ.push_back(4);
    for (int i = 0; i < 5; i++) begin
      ps2Event(9'h02E, 1'b1);
      ps2Event(9'h02E, 1'b0);
    end
    tick(60);
    checkOutput("burst_pend_peak", pendPeak, 32'd3);
    checkOutput("burst_pend_drained", {30'd0, coinPend}, 32'd0);

    autoCoin = 1'b1;
    coinExpQ.push_back(4);
    ctrlExpQ.push_back(mk(5'd0, 5'd0, 1, 0)); ctrlNameQ.push_back("auto_start1");
    joy = 16'h0020;
    tick(20);
    ctrlExpQ.push_back(12'd0); ctrlNameQ.push_back("auto_start1_rel");
    joy = 16'h0000;
    tick(20);
    autoCoin = 1'b0;
    ctrlExpQ.push_back(mk(5'd0, 5'd0, 1, 0)); ctrlNameQ.push_back("noauto_start1");
    joy = 16'h0020;
    tick(20);
    ctrlExpQ.push_back(12'd0); ctrlNameQ.push_back("noauto_start1_rel");
    joy = 16'h0000;
    tick(20);

    ps2Event(9'h02E, 1'b1);
    ps2Event(9'h02E, 1'b0);
    ps2Event(9'h02E, 1'b1);
    ps2Event(9'h02E, 1'b0);
    waitCnt = 0;
    while (!coin && waitCnt < 50) begin
      tick(1);
      waitCnt++;
    end
    checkOutput("midpulse_coin_high", {31'd0, coin}, 32'd1);
    checkOutput("midpulse_pend_one", {30'd0, coinPend}, 32'd1);
    rst_n = 1'b0;
    #1;
    checkOutput("reset_drops_coin", {31'd0, coin}, 32'd0);
    checkOutput("reset_clears_pend", {30'd0, coinPend}, 32'd0);
    tick(2);
    rst_n = 1'b1;
    tick(30);
    checkOutput("after_reset_coin_low", {31'd0, coin}, 32'd0);
    checkOutput("after_reset_pend_zero", {30'd0, coinPend}, 32'd0);

    checkOutput("ctrl_queue_drained", ctrlExpQ.size(), 32'd0);
    checkOutput("coin_queue_drained", coinExpQ.size(), 32'd0);
    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
